// File: rtl/pipe_chain_if.sv
// pipe_chain_if: upstream/downstream handshake, per-stage flush and occupancy for pipe_chain
interface pipe_chain_if #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3
);
  localparam int OCC_W = $clog2(STAGES + 1);
  logic              i_valid;
  logic [WIDTH-1:0]  i_data;
  logic              o_ready;
  logic [STAGES-1:0] i_flush;
  logic              i_ready;
  logic              o_valid;
  logic [WIDTH-1:0]  o_data;
  logic [OCC_W-1:0]  o_occupancy;
  modport slave (
    input  i_valid, i_data, i_flush, i_ready,
    output o_ready, o_valid, o_data, o_occupancy
  );
  modport master (
    output i_valid, i_data, i_flush, i_ready,
    input  o_ready, o_valid, o_data, o_occupancy
  );
endinterface

// File: rtl/pipe_chain.sv
// pipe_chain: multi-stage valid/ready register chain with per-stage flush and bubble collapse
module pipe_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic i_clk,
  input  logic i_a_rst_n,
  input  logic i_s_rst,
  pipe_chain_if.slave m
);
  logic [STAGES-1:0] valid_q, valid_d, ev, en, up_v;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [WIDTH-1:0]  up_data [STAGES];
  logic [OCC_W-1:0]  occ;
  assign ev   = valid_q & ~m.i_flush;
  assign up_v = STAGES'({ev, m.i_valid});
  // a stage may load when it or any stage between it and the output is empty
  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      assign en[k] = m.i_ready | ~(&ev[STAGES-1:k]);
      if (k == 0) begin : g_in
        assign up_data[k] = m.i_data;
      end else begin : g_mid
        assign up_data[k] = data_q[k-1];
      end
    end
  endgenerate
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    occ     = '0;
    for (int i = 0; i < STAGES; i++) begin
      valid_d[i] = en[i] ? up_v[i] : valid_q[i];
      data_d[i]  = (en[i] && up_v[i]) ? up_data[i] : data_q[i];
      occ        = occ + OCC_W'(valid_q[i]);
    end
    if (i_s_rst) begin
      valid_d = '0;
      for (int i = 0; i < STAGES; i++) data_d[i] = '0;
    end
  end
  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign m.o_ready     = en[0];
  assign m.o_valid     = ev[STAGES-1];
  assign m.o_data      = data_q[STAGES-1];
  assign m.o_occupancy = occ;
endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: scoreboard bench for pipe_chain (WIDTH=32, STAGES=3)
module tb_pipe_chain;
  logic clk = 1'b0;
  logic rst_n;
  logic s_rst;
  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  pipe_chain_if #(.WIDTH(32), .STAGES(3)) bus ();
  pipe_chain #(.WIDTH(32), .STAGES(3)) dut (
    .i_clk(clk), .i_a_rst_n(rst_n), .i_s_rst(s_rst), .m(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic kill(input logic [31:0] v);
    logic found = 1'b0;
    for (int i = 0; i < q.size(); i++)
      if (!found && q[i] == v) begin
        q.delete(i);
        found = 1'b1;
      end
    chk("kill_found", {31'b0, found}, 32'd1);
  endtask
  task automatic send(input logic [31:0] d);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask
  always @(posedge clk) begin
    if (rst_n && !s_rst) begin
      if (bus.i_valid && bus.o_ready) q.push_back(bus.i_data);
      if (bus.o_valid && bus.i_ready) begin
        if (q.size() == 0) chk("extra_out", bus.o_data, 32'hFFFF_FFFF);
        else chk("out", bus.o_data, q.pop_front());
      end
    end
  end
  initial begin
    logic [31:0] str [3] = '{32'h11, 32'h22, 32'h33};
    rst_n = 1'b0; s_rst = 1'b0;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_flush = '0; bus.i_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_occ", bus.o_occupancy, 0);
    chk("rst_data", bus.o_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.i_data = str[i];
      @(negedge clk);
      chk("str_ready", bus.o_ready, 1);
    end
    bus.i_valid = 1'b0;
    chk("str_d0", bus.o_data, 32'h11);
    chk("str_v0", bus.o_valid, 1);
    @(negedge clk);
    chk("str_d1", bus.o_data, 32'h22);
    @(negedge clk);
    chk("str_d2", bus.o_data, 32'h33);
    @(negedge clk);
    chk("str_empty", bus.o_valid, 0);
    bus.i_ready = 1'b0;
    send(32'hA);
    @(negedge clk);
    chk("bub_occ1", bus.o_occupancy, 1);
    chk("bub_rdy1", bus.o_ready, 1);
    send(32'hB);
    chk("bub_occ2", bus.o_occupancy, 2);
    chk("bub_rdy2", bus.o_ready, 1);
    send(32'hC);
    chk("bub_occ3", bus.o_occupancy, 3);
    chk("bub_rdy3", bus.o_ready, 0);
    chk("bub_head", bus.o_data, 32'hA);
    bus.i_ready = 1'b1;
    #1 chk("bub_pass_rdy", bus.o_ready, 1);
    repeat (3) @(negedge clk);
    chk("bub_drained", bus.o_occupancy, 0);
    bus.i_ready = 1'b0;
    send(32'hA);
    send(32'hB);
    send(32'hC);
    chk("fl_occ3", bus.o_occupancy, 3);
    bus.i_flush = 3'b010;
    kill(32'hB);
    @(negedge clk);
    bus.i_flush = '0;
    chk("fl_occ2", bus.o_occupancy, 2);
    chk("fl_head", bus.o_data, 32'hA);
    bus.i_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("fl_drained", bus.o_occupancy, 0);
    bus.i_ready = 1'b0;
    send(32'hA);
    repeat (2) @(negedge clk);
    chk("ofl_valid", bus.o_valid, 1);
    chk("ofl_data", bus.o_data, 32'hA);
    bus.i_flush = 3'b100;
    bus.i_ready = 1'b1;
    #1 chk("ofl_killed", bus.o_valid, 0);
    kill(32'hA);
    @(negedge clk);
    bus.i_flush = '0;
    chk("ofl_occ", bus.o_occupancy, 0);
    chk("ofl_valid2", bus.o_valid, 0);
    bus.i_ready = 1'b0;
    send(32'h55);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_data", bus.o_data, 32'h55);
      chk("stall_valid", bus.o_valid, 1);
      @(negedge clk);
    end
    s_rst = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data = 32'h66;
    kill(32'h55);
    @(negedge clk);
    s_rst = 1'b0;
    bus.i_valid = 1'b0;
    chk("srst_occ", bus.o_occupancy, 0);
    chk("srst_data", bus.o_data, 0);
    chk("srst_valid", bus.o_valid, 0);
    @(negedge clk);
    chk("srst_discard", bus.o_occupancy, 0);
    send(32'h1);
    send(32'h2);
    send(32'h3);
    chk("arst_occ3", bus.o_occupancy, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.o_valid, 0);
    chk("arst_data", bus.o_data, 0);
    chk("arst_occ", bus.o_occupancy, 0);
    chk("arst_ready", bus.o_ready, 1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.i_valid = 1'($urandom_range(0, 1));
      bus.i_data  = $urandom;
      bus.i_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("drain_q", q.size(), 0);
    chk("drain_occ", bus.o_occupancy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
